// File: rtl/rgb_seq_pkg.sv
// Purpose : shared definitions for the RGB colour sequencer (state encoding,
//           register offsets, CTRL and ENTRY field positions, channel step helper).
// Ports   : none (package). Build option RGB_SEQ_LOOP_EN is consumed by rgb_seq_ctrl.
package rgb_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FADE = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Register offsets from BASE_ADDR
   localparam logic [3:0] OFF_CTRL   = 4'd0;
   localparam logic [3:0] OFF_PRESC  = 4'd1;
   localparam logic [3:0] OFF_STATUS = 4'd2;
   localparam logic [3:0] OFF_ENTRY  = 4'd8;

   // CTRL fields
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_STOP_BIT  = 1;
   localparam int CTRL_LAST_LSB  = 8;

   // ENTRY fields
   localparam int ENT_HOLD_LSB = 24;
   localparam int ENT_R_LSB    = 16;
   localparam int ENT_G_LSB    = 8;
   localparam int ENT_B_LSB    = 0;

   // One linear fade step of a single channel toward its target.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)      return cur + 8'd1;
      else if (cur > tgt) return cur - 8'd1;
      else                return cur;
   endfunction

endpackage

// File: rtl/rgb_seq_if.sv
// Purpose : register-bus bundle between the SPI-slave register bus and the sequencer.
// Ports   : we/addr/wdat driven by the bus master; rdat/hit returned combinationally
//           by the slave. Modports: master (bus side), slave (sequencer side).
interface rgb_seq_if;
   logic        we;
   logic [6:0]  addr;
   logic [31:0] wdat;
   logic [31:0] rdat;
   logic        hit;

   modport master (output we, addr, wdat, input  rdat, hit);
   modport slave  (input  we, addr, wdat, output rdat, hit);
endinterface

// File: rtl/rgb_seq_tick.sv
// Purpose : free-running prescaler; tick_o pulses one cycle every presc_i+1 cycles.
// Latency : tick_o is combinational from the counter; a load takes effect next cycle.
// Ports   : clk, reset (sync, active-high), load_i/load_val_i (PRESC register write),
//           presc_i (current PRESC value, reload source on tick), tick_o.
module rgb_seq_tick #(
   parameter logic [15:0] PRESC_RST = 16'd47999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   input  logic [15:0] presc_i,
   output logic        tick_o
);

   logic [15:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == 16'd0);

   // A PRESC write restarts the period with the newly written value,
   // taking priority over the reload that a coincident tick would do.
   always_comb begin
      cnt_d = cnt_q - 16'd1;
      if (load_i)      cnt_d = load_val_i;
      else if (tick_o) cnt_d = presc_i;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= PRESC_RST;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rgb_seq_ctrl.sv
// Purpose : RGB colour sequencer; fades linearly through an 8-entry pattern table
//           and holds each colour, driving the PWM dimmer duty inputs.
// Ports   : clk, reset (sync, active-high), bus (rgb_seq_if.slave register bus),
//           red/grn/blu (registered duty), busy (not IDLE), done (end-of-run pulse).
// Build   : RGB_SEQ_LOOP_EN defined -> the table wraps to entry 0 forever, no done.
module rgb_seq_ctrl
   import rgb_seq_pkg::*;
#(
   parameter logic [6:0]  BASE_ADDR = 7'h10,
   parameter logic [15:0] PRESC_RST = 16'd47999
) (
   input  logic       clk,
   input  logic       reset,
   rgb_seq_if.slave   bus,
   output logic [7:0] red,
   output logic [7:0] grn,
   output logic [7:0] blu,
   output logic       busy,
   output logic       done
);

   // ---------------- register decode ----------------
   logic [6:0] off;
   logic       wr, ctrl_wr, presc_wr, entry_wr, start, stop, tick;

   assign off      = bus.addr - BASE_ADDR;
   assign bus.hit  = (bus.addr >= BASE_ADDR) && (off < 7'd16);
   assign wr       = bus.we && bus.hit;
   assign ctrl_wr  = wr && (off[3:0] == OFF_CTRL);
   assign presc_wr = wr && (off[3:0] == OFF_PRESC);
   assign entry_wr = wr && off[3];
   assign start    = ctrl_wr && bus.wdat[CTRL_START_BIT];
   assign stop     = ctrl_wr && bus.wdat[CTRL_STOP_BIT];

   // ---------------- register file ----------------
   logic [2:0]  last_q;
   logic [15:0] presc_q;
   logic [31:0] entry_q [8];

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q  <= 3'd7;
         presc_q <= PRESC_RST;
         for (int i = 0; i < 8; i++) entry_q[i] <= '0;
      end else begin
         if (ctrl_wr)  last_q  <= bus.wdat[CTRL_LAST_LSB +: 3];
         if (presc_wr) presc_q <= bus.wdat[15:0];
         if (entry_wr) entry_q[off[2:0]] <= bus.wdat;
      end
   end

   rgb_seq_tick #(.PRESC_RST(PRESC_RST)) u_tick (
      .clk        (clk),
      .reset      (reset),
      .load_i     (presc_wr),
      .load_val_i (bus.wdat[15:0]),
      .presc_i    (presc_q),
      .tick_o     (tick)
   );

   // ---------------- sequencer FSM + channel steppers ----------------
   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
   logic [7:0]  hold_q, hold_d, hcnt_q, hcnt_d;
   logic [7:0]  red_q, red_d, grn_q, grn_d, blu_q, blu_d;
   logic        done_q, done_d;
   logic [31:0] cur_entry;
   logic        at_tgt;

   assign cur_entry = entry_q[idx_q];
   assign at_tgt    = (red_q == tgt_r_q) && (grn_q == tgt_g_q) && (blu_q == tgt_b_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tgt_r_d = tgt_r_q;
      tgt_g_d = tgt_g_q;
      tgt_b_d = tgt_b_q;
      hold_d  = hold_q;
      hcnt_d  = hcnt_q;
      red_d   = red_q;
      grn_d   = grn_q;
      blu_d   = blu_q;
      done_d  = 1'b0;

      // Control writes pre-empt the FSM; stop beats start. Neither lets a
      // coincident tick move the colour, so outputs freeze exactly as seen.
      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d = ST_LOAD;
         idx_d   = 3'd0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               tgt_r_d = cur_entry[ENT_R_LSB +: 8];
               tgt_g_d = cur_entry[ENT_G_LSB +: 8];
               tgt_b_d = cur_entry[ENT_B_LSB +: 8];
               hold_d  = cur_entry[ENT_HOLD_LSB +: 8];
               hcnt_d  = 8'd0;
               state_d = ST_FADE;
            end
            ST_FADE: begin
               if (at_tgt) begin
                  state_d = ST_HOLD;
               end else if (tick) begin
                  red_d = step_toward(red_q, tgt_r_q);
                  grn_d = step_toward(grn_q, tgt_g_q);
                  blu_d = step_toward(blu_q, tgt_b_q);
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  if (hcnt_q == hold_q) begin
                     // idx beyond last (last lowered mid-run) also ends the run
                     if (idx_q < last_q) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOAD;
                     end else begin
`ifdef RGB_SEQ_LOOP_EN
                        idx_d   = 3'd0;
                        state_d = ST_LOAD;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                     end
                  end else begin
                     hcnt_d = hcnt_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         tgt_r_q <= 8'd0;
         tgt_g_q <= 8'd0;
         tgt_b_q <= 8'd0;
         hold_q  <= 8'd0;
         hcnt_q  <= 8'd0;
         red_q   <= 8'd0;
         grn_q   <= 8'd0;
         blu_q   <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tgt_r_q <= tgt_r_d;
         tgt_g_q <= tgt_g_d;
         tgt_b_q <= tgt_b_d;
         hold_q  <= hold_d;
         hcnt_q  <= hcnt_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         blu_q   <= blu_d;
         done_q  <= done_d;
      end
   end

   assign red  = red_q;
   assign grn  = grn_q;
   assign blu  = blu_q;
   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   // ---------------- read mux ----------------
   always_comb begin
      bus.rdat = '0;
      if (bus.hit) begin
         case (off[3:0])
            OFF_CTRL:   bus.rdat[CTRL_LAST_LSB +: 3] = last_q;
            OFF_PRESC:  bus.rdat[15:0] = presc_q;
            OFF_STATUS: bus.rdat = {red_q, grn_q, blu_q, 1'b0, idx_q, 1'b0, state_q, busy};
            default:    if (off[3]) bus.rdat = entry_q[off[2:0]];
         endcase
      end
   end

endmodule
